// File: rtl/ov5640_frame_ctrl.sv
// OV5640 frame capture controller: arms on a software start edge, frames capture on
// VSYNC, counts HREF lines and pixels per line, and flags frames whose geometry is off.
module ov5640_frame_ctrl #(
  parameter int EXP_LINES = 480,
  parameter int EXP_PIX   = 640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        continuous_i,
  input  logic        abort_i,
  input  logic        cam_vsync_i,
  input  logic        cam_href_i,
  input  logic        pix_valid_i,
  output logic        capture_en_o,
  output logic        busy_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic [11:0] line_cnt_o,
  output logic [11:0] pix_cnt_o,
  output logic        err_size_o
);

  localparam logic [11:0] EXP_LINES_W = 12'(EXP_LINES);
  localparam logic [11:0] EXP_PIX_W   = 12'(EXP_PIX);
  localparam logic [11:0] CNT_MAX     = 12'hFFF;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

  state_e      state_q;
  logic        start_d1_q, vsync_d1_q, href_d1_q;
  logic        rdy_q;
  logic        mode_q;
  logic        capture_en_q, busy_q, frame_start_q, frame_done_q, err_size_q;
  logic [11:0] line_cnt_q, pix_cnt_q;
  logic [11:0] line_cnt_d, pix_cnt_d;
  logic        start_rise, vsync_rise, href_fall;

  // rdy_q masks the first cycle after reset so a start level held across
  // reset release is not mistaken for a fresh request.
  assign start_rise = start_i & ~start_d1_q & rdy_q;
  assign vsync_rise = cam_vsync_i & ~vsync_d1_q;
  assign href_fall  = ~cam_href_i & href_d1_q;

  assign line_cnt_d = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + 12'd1;
  assign pix_cnt_d  = (pix_cnt_q  == CNT_MAX) ? pix_cnt_q  : pix_cnt_q  + 12'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d1_q <= 1'b0;
      vsync_d1_q <= 1'b0;
      href_d1_q  <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      start_d1_q <= start_i;
      vsync_d1_q <= cam_vsync_i;
      href_d1_q  <= cam_href_i;
      rdy_q      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      capture_en_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_size_q    <= 1'b0;
      line_cnt_q    <= 12'd0;
      pix_cnt_q     <= 12'd0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (abort_i) begin
        // Abort wins over every edge this cycle; counters and error are kept for inspection.
        state_q      <= S_IDLE;
        capture_en_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_rise) begin
              state_q    <= S_ARMED;
              mode_q     <= continuous_i;
              err_size_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
          S_ARMED: begin
            if (vsync_rise) begin
              state_q       <= S_CAPTURE;
              capture_en_q  <= 1'b1;
              frame_start_q <= 1'b1;
              line_cnt_q    <= 12'd0;
              pix_cnt_q     <= 12'd0;
            end
          end
          S_CAPTURE: begin
            if (vsync_rise) begin
              frame_done_q <= 1'b1;
              if (line_cnt_q != EXP_LINES_W) err_size_q <= 1'b1;
              if (mode_q) begin
                frame_start_q <= 1'b1;
                line_cnt_q    <= 12'd0;
                pix_cnt_q     <= 12'd0;
              end else begin
                state_q      <= S_DONE;
                capture_en_q <= 1'b0;
                busy_q       <= 1'b0;
              end
            end else if (href_fall) begin
              line_cnt_q <= line_cnt_d;
              if (pix_cnt_q != EXP_PIX_W) err_size_q <= 1'b1;
              pix_cnt_q  <= 12'd0;
            end else if (pix_valid_i && cam_href_i) begin
              pix_cnt_q <= pix_cnt_d;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign capture_en_o  = capture_en_q;
  assign busy_o        = busy_q;
  assign frame_start_o = frame_start_q;
  assign frame_done_o  = frame_done_q;
  assign line_cnt_o    = line_cnt_q;
  assign pix_cnt_o     = pix_cnt_q;
  assign err_size_o    = err_size_q;

endmodule

// File: tb/tb_ov5640_frame_ctrl.sv
// Bench for ov5640_frame_ctrl with 4 lines x 8 pixels: frame vector table, randomized
// frames against a line/pixel tally model, and hand sequences for abort/reset/continuous.
module tb_ov5640_frame_ctrl;
  localparam int EL = 4;
  localparam int EP = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic vsync = 1'b0, href = 1'b0, pv = 1'b0;
  logic capture_en, busy, frame_start, frame_done, err_size;
  logic [11:0] line_cnt, pix_cnt;

  int checks = 0, errors = 0;
  int fs_cnt = 0, fd_cnt = 0, drop_cnt = 0;
  bit mon_cont = 1'b0;

  typedef struct {
    int          nlines;
    int          bad_line;
    int          bad_pix;
    logic        exp_err;
    logic [11:0] exp_lines;
  } vec_t;

  always #5 clk = ~clk;

  ov5640_frame_ctrl #(.EXP_LINES(EL), .EXP_PIX(EP)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .continuous_i(continuous), .abort_i(abort),
    .cam_vsync_i(vsync), .cam_href_i(href), .pix_valid_i(pv),
    .capture_en_o(capture_en), .busy_o(busy), .frame_start_o(frame_start),
    .frame_done_o(frame_done), .line_cnt_o(line_cnt), .pix_cnt_o(pix_cnt),
    .err_size_o(err_size));

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (frame_done) fd_cnt++;
    if (mon_cont && !capture_en) drop_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  // One HREF line; a stray strobe may coincide with the href fall and must not count.
  task automatic send_line(input int npix, input int exp_pix);
    href = 1'b1; tick();
    for (int n = 0; n < npix; n++) begin
      pv = 1'b1; tick();
      pv = 1'b0;
      repeat ($urandom_range(1, 0)) tick();
    end
    chk("pix_cnt_in_line", pix_cnt, exp_pix);
    href = 1'b0; pv = 1'($urandom_range(1, 0)); tick();
    pv = 1'($urandom_range(1, 0)); tick();
    pv = 1'b0;
    chk("pix_cnt_cleared", pix_cnt, 0);
  endtask

  task automatic start_frame(input bit cont);
    start = 1'b0; tick();
    start = 1'b1; continuous = cont; tick();
    chk("armed_busy", busy, 1);
    chk("armed_err_clear", err_size, 0);
    start = 1'b0;
    vsync = 1'b1; tick();
    chk("frame_start", frame_start, 1);
    chk("capture_en_on", capture_en, 1);
    chk("line_cnt_zero", line_cnt, 0);
    vsync = 1'b0; tick();
    chk("frame_start_pulse", frame_start, 0);
  endtask

  task automatic end_single(input logic [11:0] el, input logic ee);
    int fd0;
    fd0 = fd_cnt;
    vsync = 1'b1; tick();
    chk("frame_done", frame_done, 1);
    chk("final_line_cnt", line_cnt, el);
    chk("final_err", err_size, ee);
    chk("done_busy", busy, 0);
    chk("done_capture_en", capture_en, 0);
    vsync = 1'b0; tick();
    chk("frame_done_pulse", frame_done, 0);
    chk("line_cnt_hold", line_cnt, el);
    chk("fd_count", fd_cnt, fd0 + 1);
  endtask

  // Sends a frame of lines with the given pixel counts; returns the model's error verdict.
  task automatic frame_body(input int nl, input int pixv[8], output logic err_m);
    err_m = 1'b0;
    for (int l = 0; l < nl; l++) begin
      send_line(pixv[l], pixv[l]);
      if (pixv[l] != EP) err_m = 1'b1;
      chk("running_err", err_size, err_m);
      chk("running_line_cnt", line_cnt, l + 1);
    end
    if (nl != EL) err_m = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    int   pixv[8];
    logic err_m;
    int   fd0, fs0;

    vecs[0] = '{nlines: 4, bad_line: -1, bad_pix: 0, exp_err: 1'b0, exp_lines: 12'd4};
    vecs[1] = '{nlines: 4, bad_line:  1, bad_pix: 7, exp_err: 1'b1, exp_lines: 12'd4};
    vecs[2] = '{nlines: 3, bad_line: -1, bad_pix: 0, exp_err: 1'b1, exp_lines: 12'd3};
    vecs[3] = '{nlines: 5, bad_line: -1, bad_pix: 0, exp_err: 1'b1, exp_lines: 12'd5};
    vecs[4] = '{nlines: 4, bad_line:  3, bad_pix: 9, exp_err: 1'b1, exp_lines: 12'd4};
    vecs[5] = '{nlines: 4, bad_line:  0, bad_pix: 0, exp_err: 1'b1, exp_lines: 12'd4};

    repeat (3) tick();
    chk("reset_outputs", {capture_en, busy, frame_start, frame_done, err_size, line_cnt, pix_cnt}, 0);
    rst_n = 1'b1; tick();
    chk("post_reset_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      for (int l = 0; l < 8; l++) pixv[l] = (l == vecs[v].bad_line) ? vecs[v].bad_pix : EP;
      start_frame(1'b0);
      frame_body(vecs[v].nlines, pixv, err_m);
      end_single(vecs[v].exp_lines, vecs[v].exp_err);
    end

    for (int r = 0; r < 20; r++) begin
      int nl;
      nl = $urandom_range(5, 3);
      for (int l = 0; l < 8; l++)
        pixv[l] = ($urandom_range(3, 0) != 0) ? EP : int'($urandom_range(9, 7));
      start_frame(1'b0);
      frame_body(nl, pixv, err_m);
      end_single(12'(nl), err_m);
    end

    // Saturation of both counters.
    start_frame(1'b0);
    href = 1'b1; pv = 1'b1;
    repeat (4100) tick();
    pv = 1'b0;
    chk("pix_cnt_saturate", pix_cnt, 4095);
    href = 1'b0; tick();
    chk("err_after_long_line", err_size, 1);
    repeat (4100) begin
      href = 1'b1; tick();
      href = 1'b0; tick();
    end
    chk("line_cnt_saturate", line_cnt, 4095);
    end_single(12'd4095, 1'b1);

    // Continuous capture; clearing continuous and a start rise mid-stream have no effect.
    start = 1'b0; tick();
    continuous = 1'b1; start = 1'b1; tick();
    chk("cont_busy", busy, 1);
    vsync = 1'b1; tick();
    chk("cont_frame_start", frame_start, 1);
    vsync = 1'b0; tick();
    mon_cont = 1'b1;
    fd0 = fd_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < EL; l++) send_line(EP, EP);
      if (f == 0) continuous = 1'b0;
      if (f == 1) begin
        start = 1'b0; tick();
        start = 1'b1; tick();
        chk("midstream_start_busy", busy, 1);
        chk("midstream_start_cap", capture_en, 1);
      end
      vsync = 1'b1; tick();
      chk("cont_frame_done", frame_done, 1);
      chk("cont_coincident_start", frame_start, 1);
      chk("cont_line_cleared", line_cnt, 0);
      chk("cont_err", err_size, 0);
      chk("cont_capture_en", capture_en, 1);
      vsync = 1'b0; tick();
    end
    mon_cont = 1'b0;
    chk("cont_fd_count", fd_cnt - fd0, 3);
    chk("cont_no_drop", drop_cnt, 0);
    abort = 1'b1; tick();
    chk("cont_abort_cap", capture_en, 0);
    chk("cont_abort_busy", busy, 0);
    abort = 1'b0; start = 1'b0; tick();

    // Abort during line 3; a later vsync is ignored.
    start_frame(1'b0);
    send_line(EP, EP);
    send_line(EP, EP);
    href = 1'b1; tick();
    repeat (3) begin pv = 1'b1; tick(); pv = 1'b0; end
    fd0 = fd_cnt;
    abort = 1'b1; tick();
    chk("abort_cap", capture_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_line_hold", line_cnt, 2);
    abort = 1'b0; href = 1'b0; tick();
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    chk("abort_no_done", fd_cnt, fd0);
    chk("abort_vsync_ignored", busy, 0);

    // Abort with vsync rise at frame end suppresses frame_done.
    start_frame(1'b0);
    for (int l = 0; l < EL; l++) send_line(EP, EP);
    fd0 = fd_cnt;
    abort = 1'b1; vsync = 1'b1; tick();
    chk("abort_vs_done", frame_done, 0);
    chk("abort_vs_line_hold", line_cnt, 4);
    abort = 1'b0; vsync = 1'b0; tick();
    chk("abort_vs_fd_count", fd_cnt, fd0);

    // Abort beats vsync rise out of ARMED.
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("armed2_busy", busy, 1);
    fs0 = fs_cnt;
    abort = 1'b1; vsync = 1'b1; tick();
    chk("abort_armed_busy", busy, 0);
    abort = 1'b0; vsync = 1'b0; tick();
    chk("abort_armed_no_start", fs_cnt, fs0);

    // Start rise coincident with abort is dropped.
    start = 1'b0; tick();
    start = 1'b1; abort = 1'b1; tick();
    abort = 1'b0; tick();
    chk("start_with_abort_busy", busy, 0);
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    chk("start_with_abort_cap", capture_en, 0);

    // Reset mid-frame, with start held high across release.
    start_frame(1'b0);
    send_line(7, 7);
    chk("err_before_reset", err_size, 1);
    start = 1'b1;
    rst_n = 1'b0; #1;
    chk("reset_err_clear", err_size, 0);
    chk("reset_cap", capture_en, 0);
    chk("reset_line", line_cnt, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    fs0 = fs_cnt;
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    chk("held_start_busy", busy, 0);
    chk("held_start_no_frame", fs_cnt, fs0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("fresh_start_busy", busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
